load_store_unit_l4: RTL and testbench

// Pipelined load/store execute unit: takes D->X ops, issues memory requests,

---
 rtl/load_store_unit_l4.sv | 248 ++++++++++++++++++++++++
 tb/tb_load_store_unit_l4.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_l4.sv
// Load/store execute unit: a one-entry issue stage feeding an in-order tracker
// that pairs memory responses with writeback records.
module load_store_unit_l4 #(
  parameter int unsigned p_opaq_bits      = 8,
  parameter int unsigned p_seq_num_bits   = 5,
  parameter int unsigned p_phys_addr_bits = 6,
  parameter int unsigned p_max_inflight   = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_d_val,
  output logic                        o_d_rdy,
  input  logic [31:0]                 i_d_pc,
  input  logic [31:0]                 i_d_op1,
  input  logic [31:0]                 i_d_op2,
  input  logic [31:0]                 i_d_op3,
  input  logic [p_seq_num_bits-1:0]   i_d_seq_num,
  input  logic [4:0]                  i_d_waddr,
  input  logic [p_phys_addr_bits-1:0] i_d_preg,
  input  logic [p_phys_addr_bits-1:0] i_d_ppreg,
  input  logic [3:0]                  i_d_uop,
  output logic                        o_mem_req_val,
  input  logic                        i_mem_req_rdy,
  output logic                        o_mem_req_op,
  output logic [p_opaq_bits-1:0]      o_mem_req_opaque,
  output logic [31:0]                 o_mem_req_addr,
  output logic [3:0]                  o_mem_req_strb,
  output logic [31:0]                 o_mem_req_data,
  input  logic                        i_mem_resp_val,
  output logic                        o_mem_resp_rdy,
  input  logic [31:0]                 i_mem_resp_data,
  input  logic [p_opaq_bits-1:0]      i_mem_resp_opaque,
  output logic                        o_w_val,
  input  logic                        i_w_rdy,
  output logic [31:0]                 o_w_pc,
  output logic [31:0]                 o_w_wdata,
  output logic [p_seq_num_bits-1:0]   o_w_seq_num,
  output logic [4:0]                  o_w_waddr,
  output logic [p_phys_addr_bits-1:0] o_w_preg,
  output logic [p_phys_addr_bits-1:0] o_w_ppreg,
  output logic                        o_w_wen,
  output logic                        o_w_misalign
);

  localparam int unsigned LP_PTR_W = $clog2(p_max_inflight);
  localparam int unsigned LP_CNT_W = LP_PTR_W + 1;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic MEM_MSG_READ  = 1'b0;
  localparam logic MEM_MSG_WRITE = 1'b1;

  typedef struct packed {
    logic [31:0]                 pc;
    logic [p_seq_num_bits-1:0]   seq_num;
    logic [4:0]                  waddr;
    logic [p_phys_addr_bits-1:0] preg;
    logic [p_phys_addr_bits-1:0] ppreg;
    logic [1:0]                  size;
    logic                        sgn;
    logic [1:0]                  lane;
    logic                        is_load;
    logic                        misal;
  } trk_entry_t;

  logic                        r_s1_val;
  logic [31:0]                 r_s1_pc;
  logic [31:0]                 r_s1_addr;
  logic [31:0]                 r_s1_op3;
  logic [p_seq_num_bits-1:0]   r_s1_seq_num;
  logic [4:0]                  r_s1_waddr;
  logic [p_phys_addr_bits-1:0] r_s1_preg;
  logic [p_phys_addr_bits-1:0] r_s1_ppreg;
  logic [3:0]                  r_s1_uop;

  trk_entry_t                  r_trk [p_max_inflight];
  logic [LP_PTR_W-1:0]         r_head;
  logic [LP_PTR_W-1:0]         r_tail;
  logic [LP_CNT_W-1:0]         r_count;

  logic [1:0]  w_size;
  logic        w_sgn;
  logic        w_load;
  logic        w_misal;
  logic        w_full;
  logic        w_issue;
  logic        w_d_xfer;
  logic        w_head_val;
  logic        w_deq;
  logic [31:0] w_shift;
  logic [31:0] w_ext;
  trk_entry_t  w_head;
  trk_entry_t  w_new;

  // Decode the staged uop; unknown encodings behave as LW.
  always_comb begin
    w_size = SZ_W;
    w_sgn  = 1'b0;
    w_load = 1'b1;
    case (r_s1_uop)
      OP_LB:   begin w_size = SZ_B; w_sgn = 1'b1; end
      OP_LH:   begin w_size = SZ_H; w_sgn = 1'b1; end
      OP_LBU:  w_size = SZ_B;
      OP_LHU:  w_size = SZ_H;
      OP_SB:   begin w_size = SZ_B; w_load = 1'b0; end
      OP_SH:   begin w_size = SZ_H; w_load = 1'b0; end
      OP_SW:   w_load = 1'b0;
      OP_LW:   w_size = SZ_W;
      default: w_size = SZ_W;
    endcase
  end

  assign w_misal = ((w_size == SZ_H) & r_s1_addr[0]) |
                   ((w_size == SZ_W) & (r_s1_addr[1:0] != 2'b00));
  assign w_full  = (r_count == LP_CNT_W'(p_max_inflight));
  assign w_issue = r_s1_val & ~w_full & (w_misal | i_mem_req_rdy);

  assign o_d_rdy  = i_rst_n & (~r_s1_val | w_issue);
  assign w_d_xfer = i_d_val & o_d_rdy;

  assign o_mem_req_val    = r_s1_val & ~w_misal & ~w_full;
  assign o_mem_req_op     = w_load ? MEM_MSG_READ : MEM_MSG_WRITE;
  assign o_mem_req_opaque = p_opaq_bits'(r_tail);
  assign o_mem_req_addr   = {r_s1_addr[31:2], 2'b00};

  // Byte lanes and store data replicated across the word.
  always_comb begin
    o_mem_req_strb = 4'hF;
    o_mem_req_data = r_s1_op3;
    case (w_size)
      SZ_B: begin
        o_mem_req_strb = 4'b0001 << r_s1_addr[1:0];
        o_mem_req_data = {4{r_s1_op3[7:0]}};
      end
      SZ_H: begin
        o_mem_req_strb = 4'b0011 << r_s1_addr[1:0];
        o_mem_req_data = {2{r_s1_op3[15:0]}};
      end
      default: begin
        o_mem_req_strb = 4'hF;
        o_mem_req_data = r_s1_op3;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_val     <= 1'b0;
      r_s1_pc      <= '0;
      r_s1_addr    <= '0;
      r_s1_op3     <= '0;
      r_s1_seq_num <= '0;
      r_s1_waddr   <= '0;
      r_s1_preg    <= '0;
      r_s1_ppreg   <= '0;
      r_s1_uop     <= '0;
    end else if (w_d_xfer) begin
      r_s1_val     <= 1'b1;
      r_s1_pc      <= i_d_pc;
      r_s1_addr    <= i_d_op1 + i_d_op2;
      r_s1_op3     <= i_d_op3;
      r_s1_seq_num <= i_d_seq_num;
      r_s1_waddr   <= i_d_waddr;
      r_s1_preg    <= i_d_preg;
      r_s1_ppreg   <= i_d_ppreg;
      r_s1_uop     <= i_d_uop;
    end else if (w_issue) begin
      r_s1_val     <= 1'b0;
    end
  end

  always_comb begin
    w_new         = '0;
    w_new.pc      = r_s1_pc;
    w_new.seq_num = r_s1_seq_num;
    w_new.waddr   = r_s1_waddr;
    w_new.preg    = r_s1_preg;
    w_new.ppreg   = r_s1_ppreg;
    w_new.size    = w_size;
    w_new.sgn     = w_sgn;
    w_new.lane    = r_s1_addr[1:0];
    w_new.is_load = w_load;
    w_new.misal   = w_misal;
  end

  // Tracker payload needs no reset; occupancy is carried by the pointers.
  always_ff @(posedge i_clk) begin
    if (w_issue) r_trk[r_tail] <= w_new;
  end

  assign w_head     = r_trk[r_head];
  assign w_head_val = (r_count != '0);
  assign o_w_val        = w_head_val & (w_head.misal | i_mem_resp_val);
  assign o_mem_resp_rdy = w_head_val & ~w_head.misal & i_w_rdy;
  assign w_deq          = o_w_val & i_w_rdy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_issue) r_tail <= r_tail + LP_PTR_W'(1);
      if (w_deq)   r_head <= r_head + LP_PTR_W'(1);
      r_count <= r_count + LP_CNT_W'(w_issue) - LP_CNT_W'(w_deq);
    end
  end

  // Align the returned word to the accessed lane and extend.
  assign w_shift = i_mem_resp_data >> {w_head.lane, 3'b000};
  always_comb begin
    w_ext = w_shift;
    case (w_head.size)
      SZ_B:    w_ext = {{24{w_head.sgn & w_shift[7]}}, w_shift[7:0]};
      SZ_H:    w_ext = {{16{w_head.sgn & w_shift[15]}}, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
  end

  assign o_w_pc       = w_head.pc;
  assign o_w_seq_num  = w_head.seq_num;
  assign o_w_waddr    = w_head.waddr;
  assign o_w_preg     = w_head.preg;
  assign o_w_ppreg    = w_head.ppreg;
  assign o_w_wen      = w_head.is_load & ~w_head.misal;
  assign o_w_misalign = w_head.misal;
  assign o_w_wdata    = (w_head.is_load & ~w_head.misal) ? w_ext : 32'h0;

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (i_rst_n && i_mem_resp_val && o_mem_resp_rdy)
      assert (i_mem_resp_opaque == p_opaq_bits'(r_head))
        else $error("mem_resp_opaque %0d does not match head slot %0d", i_mem_resp_opaque, r_head);
  end
`endif

endmodule

// File: tb/tb_load_store_unit_l4.sv
// Bench for load_store_unit_l4: directed cases then randomized traffic checked
// against a queue-based model of requests and writebacks.
module tb_load_store_unit_l4;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;

  logic        clk;
  logic        i_rst_n;
  logic        i_d_val, o_d_rdy;
  logic [31:0] i_d_pc, i_d_op1, i_d_op2, i_d_op3;
  logic [4:0]  i_d_seq_num, i_d_waddr;
  logic [5:0]  i_d_preg, i_d_ppreg;
  logic [3:0]  i_d_uop;
  logic        o_mem_req_val, i_mem_req_rdy, o_mem_req_op;
  logic [7:0]  o_mem_req_opaque;
  logic [31:0] o_mem_req_addr, o_mem_req_data;
  logic [3:0]  o_mem_req_strb;
  logic        i_mem_resp_val, o_mem_resp_rdy;
  logic [31:0] i_mem_resp_data;
  logic [7:0]  i_mem_resp_opaque;
  logic        o_w_val, i_w_rdy;
  logic [31:0] o_w_pc, o_w_wdata;
  logic [4:0]  o_w_seq_num, o_w_waddr;
  logic [5:0]  o_w_preg, o_w_ppreg;
  logic        o_w_wen, o_w_misalign;

  load_store_unit_l4 dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_d_val(i_d_val), .o_d_rdy(o_d_rdy),
    .i_d_pc(i_d_pc), .i_d_op1(i_d_op1), .i_d_op2(i_d_op2), .i_d_op3(i_d_op3),
    .i_d_seq_num(i_d_seq_num), .i_d_waddr(i_d_waddr),
    .i_d_preg(i_d_preg), .i_d_ppreg(i_d_ppreg), .i_d_uop(i_d_uop),
    .o_mem_req_val(o_mem_req_val), .i_mem_req_rdy(i_mem_req_rdy),
    .o_mem_req_op(o_mem_req_op), .o_mem_req_opaque(o_mem_req_opaque),
    .o_mem_req_addr(o_mem_req_addr), .o_mem_req_strb(o_mem_req_strb),
    .o_mem_req_data(o_mem_req_data),
    .i_mem_resp_val(i_mem_resp_val), .o_mem_resp_rdy(o_mem_resp_rdy),
    .i_mem_resp_data(i_mem_resp_data), .i_mem_resp_opaque(i_mem_resp_opaque),
    .o_w_val(o_w_val), .i_w_rdy(i_w_rdy),
    .o_w_pc(o_w_pc), .o_w_wdata(o_w_wdata), .o_w_seq_num(o_w_seq_num),
    .o_w_waddr(o_w_waddr), .o_w_preg(o_w_preg), .o_w_ppreg(o_w_ppreg),
    .o_w_wen(o_w_wen), .o_w_misalign(o_w_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, op1, op2, op3;
    logic [4:0]  seq, waddr;
    logic [5:0]  preg, ppreg;
    logic [3:0]  uop;
  } op_t;

  typedef struct {
    logic [31:0] addr, strb, data, op, opq;
  } req_t;

  op_t         stim_q[$];
  op_t         w_q[$];
  req_t        req_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] resp_data_q[$];
  logic [31:0] opq_hist[$];
  logic [31:0] wd_hist[$];

  int n_vec = 0;
  int n_err = 0;
  int unsigned k_ops;
  int p_dval, p_req_rdy, p_resp, p_w_rdy;
  bit d_hold, resp_hold, prev_wstall;
  logic [31:0] prev_pc, prev_wdata;
  logic [31:0] last_req_addr, last_req_strb, last_req_data, last_req_op;
  logic        last_w_wen, last_w_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned op_bytes(input logic [3:0] u);
    case (u)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic bit op_is_load(input logic [3:0] u);
    return !(u == OP_SB || u == OP_SH || u == OP_SW);
  endfunction

  function automatic bit op_signed(input logic [3:0] u);
    return (u == OP_LB || u == OP_LH);
  endfunction

  function automatic bit op_misal(input op_t o);
    logic [31:0] a;
    a = o.op1 + o.op2;
    return (a % op_bytes(o.uop)) != 0;
  endfunction

  function automatic req_t exp_req(input op_t o, input int unsigned slot);
    req_t r;
    logic [31:0] a;
    int unsigned nb;
    a  = o.op1 + o.op2;
    nb = op_bytes(o.uop);
    r.addr = a - (a % 4);
    r.strb = ((1 << nb) - 1) << (a % 4);
    if (nb == 1)      r.data = o.op3[7:0] * 32'h01010101;
    else if (nb == 2) r.data = o.op3[15:0] * 32'h00010001;
    else              r.data = o.op3;
    r.op  = op_is_load(o.uop) ? 32'd0 : 32'd1;
    r.opq = slot;
    return r;
  endfunction

  function automatic logic [31:0] exp_wdata(input op_t o, input logic [31:0] resp);
    logic [31:0] a, v;
    int unsigned nb;
    if (!op_is_load(o.uop) || op_misal(o)) return 32'h0;
    a  = o.op1 + o.op2;
    nb = op_bytes(o.uop);
    v  = resp >> (8 * (a % 4));
    if (nb == 1) begin
      v = v & 32'hFF;
      if (op_signed(o.uop) && v >= 32'd128) v = v - 32'd256;
    end else if (nb == 2) begin
      v = v & 32'hFFFF;
      if (op_signed(o.uop) && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  function automatic bit rnd(input int p);
    return ($urandom % 100) < p;
  endfunction

  function automatic logic [31:0] busy();
    return stim_q.size() + req_q.size() + w_q.size() + mem_q.size();
  endfunction

  task automatic push_op(input logic [3:0] u, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] s);
    op_t o;
    o.pc = $urandom; o.op1 = a; o.op2 = b; o.op3 = s; o.uop = u;
    o.seq = 5'($urandom); o.waddr = 5'($urandom);
    o.preg = 6'($urandom); o.ppreg = 6'($urandom);
    stim_q.push_back(o);
  endtask

  task automatic knobs(input int d, input int q, input int r, input int w);
    p_dval = d; p_req_rdy = q; p_resp = r; p_w_rdy = w;
  endtask

  task automatic clear_model();
    stim_q.delete(); w_q.delete(); req_q.delete(); mem_q.delete();
    resp_data_q.delete(); opq_hist.delete(); wd_hist.delete();
    k_ops = 0; d_hold = 0; resp_hold = 0; prev_wstall = 0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_d_val = 1'b0; i_mem_req_rdy = 1'b0; i_mem_resp_val = 1'b0; i_w_rdy = 1'b0;
    clear_model();
    knobs(100, 100, 100, 100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    op_t o;
    if (!d_hold) begin
      if (stim_q.size() > 0 && rnd(p_dval)) begin
        o = stim_q[0];
        i_d_pc = o.pc; i_d_op1 = o.op1; i_d_op2 = o.op2; i_d_op3 = o.op3;
        i_d_seq_num = o.seq; i_d_waddr = o.waddr; i_d_preg = o.preg;
        i_d_ppreg = o.ppreg; i_d_uop = o.uop;
        i_d_val = 1'b1; d_hold = 1;
      end else i_d_val = 1'b0;
    end
    i_mem_req_rdy = rnd(p_req_rdy);
    if (!resp_hold) begin
      if (mem_q.size() > 0 && rnd(p_resp)) begin
        i_mem_resp_data   = (resp_data_q.size() > 0) ? resp_data_q.pop_front() : $urandom;
        i_mem_resp_opaque = 8'(mem_q[0]);
        i_mem_resp_val    = 1'b1;
        resp_hold         = 1;
      end else i_mem_resp_val = 1'b0;
    end
    i_w_rdy = rnd(p_w_rdy);
  endtask

  // One cycle: drive at edge+1, check at edge+2, then advance the model.
  task automatic tick();
    req_t e;
    op_t  w;
    bit   d_x, req_x, resp_x, w_x;
    drive();
    #1;
    if (o_mem_req_val) begin
      if (req_q.size() == 0) chk("req_unexpected", 1, 0);
      else begin
        e = req_q[0];
        chk("req_addr", o_mem_req_addr, e.addr);
        chk("req_strb", o_mem_req_strb, e.strb);
        chk("req_data", o_mem_req_data, e.data);
        chk("req_op", o_mem_req_op, e.op);
        chk("req_opaque", o_mem_req_opaque, e.opq);
      end
    end
    if (prev_wstall) begin
      chk("w_hold_val", o_w_val, 1);
      chk("w_hold_pc", o_w_pc, prev_pc);
      chk("w_hold_wdata", o_w_wdata, prev_wdata);
    end
    if (i_mem_resp_val && !i_w_rdy) chk("resp_rdy_backpressure", o_mem_resp_rdy, 0);
    if (o_w_val) begin
      if (w_q.size() == 0) chk("w_unexpected", 1, 0);
      else begin
        w = w_q[0];
        chk("w_pc", o_w_pc, w.pc);
        chk("w_seq", o_w_seq_num, w.seq);
        chk("w_waddr", o_w_waddr, w.waddr);
        chk("w_preg", o_w_preg, w.preg);
        chk("w_ppreg", o_w_ppreg, w.ppreg);
        chk("w_misalign", o_w_misalign, op_misal(w));
        chk("w_wen", o_w_wen, op_is_load(w.uop) && !op_misal(w));
        chk("w_wdata", o_w_wdata, exp_wdata(w, i_mem_resp_data));
      end
    end
    d_x    = i_d_val && o_d_rdy;
    req_x  = o_mem_req_val && i_mem_req_rdy;
    resp_x = i_mem_resp_val && o_mem_resp_rdy;
    w_x    = o_w_val && i_w_rdy;
    if (resp_x) chk("resp_with_w", w_x, 1);
    prev_wstall = o_w_val && !i_w_rdy;
    prev_pc     = o_w_pc;
    prev_wdata  = o_w_wdata;
    if (resp_x && mem_q.size() > 0) begin
      void'(mem_q.pop_front());
      resp_hold = 0;
    end
    if (req_x && req_q.size() > 0) begin
      last_req_addr = o_mem_req_addr; last_req_strb = 32'(o_mem_req_strb);
      last_req_data = o_mem_req_data; last_req_op = 32'(o_mem_req_op);
      opq_hist.push_back(32'(o_mem_req_opaque));
      mem_q.push_back(32'(o_mem_req_opaque));
      void'(req_q.pop_front());
    end
    if (w_x && w_q.size() > 0) begin
      last_w_wen = o_w_wen; last_w_mis = o_w_misalign;
      wd_hist.push_back(o_w_wdata);
      void'(w_q.pop_front());
    end
    if (d_x) begin
      w = stim_q.pop_front();
      w_q.push_back(w);
      if (!op_misal(w)) req_q.push_back(exp_req(w, k_ops % 4));
      k_ops++;
      d_hold = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_idle(input int max);
    int c = 0;
    while (busy() != 0 && c < max) begin
      tick();
      c++;
    end
    chk("drain", busy(), 0);
  endtask

  initial begin
    i_rst_n = 1'b1;
    i_d_val = 1'b0; i_mem_req_rdy = 1'b0; i_mem_resp_val = 1'b0; i_w_rdy = 1'b0;
    i_d_pc = '0; i_d_op1 = '0; i_d_op2 = '0; i_d_op3 = '0; i_d_seq_num = '0;
    i_d_waddr = '0; i_d_preg = '0; i_d_ppreg = '0; i_d_uop = '0;
    i_mem_resp_data = '0; i_mem_resp_opaque = '0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_w_val", o_w_val, 0);
    chk("rst_req_val", o_mem_req_val, 0);
    chk("rst_d_rdy", o_d_rdy, 0);
    chk("rst_resp_rdy", o_mem_resp_rdy, 0);
    do_reset();
    chk("post_rst_d_rdy", o_d_rdy, 1);

    // Byte store to the top lane.
    push_op(OP_SB, 32'h1000, 32'd3, 32'hAB);
    run_idle(50);
    chk("sb_addr", last_req_addr, 32'h1000);
    chk("sb_strb", last_req_strb, 32'h8);
    chk("sb_data", last_req_data, 32'hABABABAB);
    chk("sb_op", last_req_op, 1);
    chk("sb_wen", last_w_wen, 0);

    // Sub-word loads with sign/zero extension.
    do_reset();
    resp_data_q.push_back(32'h80FFFFFF);
    resp_data_q.push_back(32'h80FFFFFF);
    resp_data_q.push_back(32'h80010000);
    push_op(OP_LB, 32'h1000, 32'd3, 32'h0);
    push_op(OP_LBU, 32'h1000, 32'd3, 32'h0);
    push_op(OP_LH, 32'h1000, 32'd2, 32'h0);
    run_idle(50);
    chk("ld_count", wd_hist.size(), 3);
    if (wd_hist.size() == 3) begin
      chk("lb_wdata", wd_hist[0], 32'hFFFFFF80);
      chk("lbu_wdata", wd_hist[1], 32'h00000080);
      chk("lh_wdata", wd_hist[2], 32'hFFFF8001);
    end

    // Tracker fills at four; the fifth op waits in the issue stage.
    do_reset();
    knobs(100, 100, 0, 100);
    for (int i = 0; i < 5; i++) push_op(OP_LW, 32'h2000, 32'(4 * i), 32'h0);
    run(10);
    chk("full_reqs", opq_hist.size(), 4);
    for (int i = 0; i < 4 && i < opq_hist.size(); i++) chk("full_opaque", opq_hist[i], i);
    chk("full_d_rdy", o_d_rdy, 0);
    chk("full_req_val", o_mem_req_val, 0);
    chk("full_w_val", o_w_val, 0);
    knobs(100, 100, 100, 100);
    run_idle(60);
    chk("full_reqs_all", opq_hist.size(), 5);
    if (opq_hist.size() == 5) chk("fifth_opaque", opq_hist[4], 0);
    chk("full_w_count", wd_hist.size(), 5);

    // Misaligned word behind an outstanding load.
    do_reset();
    knobs(100, 100, 0, 100);
    push_op(OP_LW, 32'h1000, 32'd0, 32'h0);
    push_op(OP_LW, 32'h1000, 32'd2, 32'h0);
    run(6);
    chk("mis_reqs", opq_hist.size(), 1);
    chk("mis_w_blocked", o_w_val, 0);
    knobs(100, 100, 100, 100);
    run_idle(40);
    chk("mis_w_count", wd_hist.size(), 2);
    chk("mis_flag", last_w_mis, 1);
    chk("mis_wen", last_w_wen, 0);
    if (wd_hist.size() == 2) chk("mis_wdata", wd_hist[1], 0);

    // Writeback backpressure holds the response.
    do_reset();
    knobs(100, 100, 100, 0);
    push_op(OP_LH, 32'h3000, 32'd2, 32'h0);
    run(6);
    chk("bp_w_val", o_w_val, 1);
    chk("bp_resp_rdy", o_mem_resp_rdy, 0);
    knobs(100, 100, 100, 100);
    run_idle(40);

    // Reset with two loads outstanding.
    do_reset();
    knobs(100, 100, 0, 100);
    push_op(OP_LW, 32'h4000, 32'd0, 32'h0);
    push_op(OP_LW, 32'h4000, 32'd4, 32'h0);
    run(6);
    chk("pre_rst_reqs", opq_hist.size(), 2);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_w_val", o_w_val, 0);
    chk("mid_rst_req_val", o_mem_req_val, 0);
    chk("mid_rst_d_rdy", o_d_rdy, 0);
    chk("mid_rst_resp_rdy", o_mem_resp_rdy, 0);
    do_reset();
    chk("after_rst_d_rdy", o_d_rdy, 1);
    push_op(OP_LW, 32'h5000, 32'd8, 32'h0);
    run_idle(30);
    chk("after_rst_reqs", opq_hist.size(), 1);
    if (opq_hist.size() == 1) chk("after_rst_opaque", opq_hist[0], 0);

    // Randomized traffic with random stalls on every handshake.
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      knobs($urandom_range(40, 100), $urandom_range(30, 100),
            $urandom_range(30, 100), $urandom_range(30, 100));
      for (int i = 0; i < 75; i++) begin
        int unsigned r;
        logic [3:0] u;
        r = $urandom % 10;
        u = (r < 8) ? 4'(r) : ((r == 8) ? 4'hF : 4'h9);
        push_op(u, $urandom, 32'($urandom_range(0, 15)), $urandom);
      end
      run_idle(4000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
